// File: rtl/neuron_update_engine_pkg.sv
// Shared constants, FSM encoding and saturation helper for the neuron update engine.
package neuron_update_engine_pkg;

  // Q8.8 state words: MSB index and full signed width
  localparam int unsigned Q_MSB = 16;
  localparam int unsigned Q_W   = Q_MSB + 1;

  // Signed intermediate width; covers 10*v*v with headroom
  localparam int unsigned ACC_W = 40;

  // Izhikevich model defaults in Q8.8
  localparam int A_DEF     = 5;
  localparam int B_DEF     = 51;
  localparam int C_DEF     = -16640;
  localparam int D_DEF     = 2048;
  localparam int VPEAK_DEF = 7680;

  // Clamp limits of a Q_W-bit signed word
  localparam int Q_MAX = (1 << (Q_W - 1)) - 1;
  localparam int Q_MIN = -(1 << (Q_W - 1));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MUL   = 3'd2,
    ACC   = 3'd3,
    WRITE = 3'd4
  } state_t;

  // Clamp a wide intermediate into the signed state-word range
  function automatic logic signed [Q_W-1:0] sat(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'(Q_MAX);
    lo = ACC_W'(Q_MIN);
    if (x > hi) begin
      sat = Q_W'(hi);
    end else if (x < lo) begin
      sat = Q_W'(lo);
    end else begin
      sat = Q_W'(x);
    end
  endfunction

endpackage

// File: rtl/neuron_update_engine_if.sv
// State-memory / control bus between the update engine and its surroundings.
interface neuron_update_engine_if #(
  parameter int unsigned NUMWIDTH = 16,
  parameter int unsigned TAGBITS  = 1
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [TAGBITS-1:0]        tag;
  logic signed [NUMWIDTH:0]  v_in;
  logic signed [NUMWIDTH:0]  u_in;
  logic signed [NUMWIDTH:0]  i_in;
  logic signed [NUMWIDTH:0]  v_new;
  logic signed [NUMWIDTH:0]  u_new;
  logic                      write_en;
  logic                      spike_valid;
  logic [TAGBITS-1:0]        spike_tag;

  // Controller / state-memory side
  modport master (
    output start, v_in, u_in, i_in,
    input  busy, done, tag, v_new, u_new, write_en, spike_valid, spike_tag
  );

  // Engine side
  modport slave (
    input  start, v_in, u_in, i_in,
    output busy, done, tag, v_new, u_new, write_en, spike_valid, spike_tag
  );
endinterface

// File: rtl/neuron_update_engine_datapath.sv
// Combinational Izhikevich update for one neuron: (v, u, i) -> (v_next, u_next, fired).
module izh_datapath
  import neuron_update_engine_pkg::*;
#(
  parameter int A     = A_DEF,
  parameter int B     = B_DEF,
  parameter int C     = C_DEF,
  parameter int D     = D_DEF,
  parameter int VPEAK = VPEAK_DEF
) (
  input  logic signed [Q_W-1:0] v,
  input  logic signed [Q_W-1:0] u,
  input  logic signed [Q_W-1:0] i,
  output logic signed [Q_W-1:0] v_next,
  output logic signed [Q_W-1:0] u_next,
  output logic                  fired
);

  localparam logic signed [ACC_W-1:0] K_A     = ACC_W'(A);
  localparam logic signed [ACC_W-1:0] K_B     = ACC_W'(B);
  localparam logic signed [ACC_W-1:0] K_C     = ACC_W'(C);
  localparam logic signed [ACC_W-1:0] K_D     = ACC_W'(D);
  localparam logic signed [ACC_W-1:0] K_VPEAK = ACC_W'(VPEAK);
  localparam logic signed [ACC_W-1:0] K_TEN   = ACC_W'(10);
  localparam logic signed [ACC_W-1:0] K_FIVE  = ACC_W'(5);
  // 140.0 in Q8.8
  localparam logic signed [ACC_W-1:0] K_REST  = ACC_W'(35840);

  logic signed [ACC_W-1:0] v_x, u_x, i_x;
  logic signed [ACC_W-1:0] quad, v_sum, bv, adu, u_sum;

  // Wide signed evaluation; >>> floors toward negative infinity
  always_comb begin
    v_x    = ACC_W'(v);
    u_x    = ACC_W'(u);
    i_x    = ACC_W'(i);
    quad   = (K_TEN * v_x * v_x) >>> 16;
    v_sum  = v_x + quad + (K_FIVE * v_x) + K_REST - u_x + i_x;
    bv     = (K_B * v_x) >>> 8;
    adu    = (K_A * (bv - u_x)) >>> 8;
    u_sum  = u_x + adu;
    fired  = (v_x >= K_VPEAK);
    if (fired) begin
      v_next = Q_W'(K_C);
      u_next = sat(u_x + K_D);
    end else begin
      v_next = sat(v_sum);
      u_next = sat(u_sum);
    end
  end

endmodule

// File: rtl/neuron_update_engine.sv
// Sweeps all neurons once per start: read state, compute update, write back, flag spikes.
module neuron_update_engine
  import neuron_update_engine_pkg::*;
#(
  parameter int unsigned NUMWIDTH   = Q_MSB,
  parameter int unsigned NUMNEURONS = 2,
  parameter int unsigned TAGBITS    = 1,
  parameter int          A          = A_DEF,
  parameter int          B          = B_DEF,
  parameter int          C          = C_DEF,
  parameter int          D          = D_DEF,
  parameter int          VPEAK      = VPEAK_DEF
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  neuron_update_engine_if.slave bus
);

  localparam int unsigned      QW       = NUMWIDTH + 1;
  localparam logic [TAGBITS-1:0] LAST_TAG = TAGBITS'(NUMNEURONS - 1);

  state_t             state_q, state_d;
  logic [TAGBITS-1:0] tag_q, tag_d;

  logic signed [QW-1:0] v_r, u_r, i_r;
  logic signed [QW-1:0] v_nx_c, u_nx_c;
  logic signed [QW-1:0] v_nx_r, u_nx_r;
  logic signed [QW-1:0] v_new_q, u_new_q;
  logic                 fired_c, fired_r;
  logic                 busy_q, done_q, we_q, spk_q;
  logic [TAGBITS-1:0]   spk_tag_q;

  izh_datapath #(
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .VPEAK (VPEAK)
  ) u_dp (
    .v      (v_r),
    .u      (u_r),
    .i      (i_r),
    .v_next (v_nx_c),
    .u_next (u_nx_c),
    .fired  (fired_c)
  );

  // State and tag registers
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  // Next state and tag; a start coinciding with done is dropped
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          state_d = READ;
          tag_d   = '0;
        end
      end
      READ:  state_d = MUL;
      MUL:   state_d = ACC;
      ACC:   state_d = WRITE;
      WRITE: begin
        if (tag_q == LAST_TAG) begin
          state_d = IDLE;
          tag_d   = '0;
        end else begin
          state_d = READ;
          tag_d   = tag_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tag_d   = '0;
      end
    endcase
  end

  // Operand capture in READ, datapath result capture in MUL
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      v_r     <= '0;
      u_r     <= '0;
      i_r     <= '0;
      v_nx_r  <= '0;
      u_nx_r  <= '0;
      fired_r <= 1'b0;
    end else begin
      if (state_q == READ) begin
        v_r <= bus.v_in;
        u_r <= bus.u_in;
        i_r <= bus.i_in;
      end
      if (state_q == MUL) begin
        v_nx_r  <= v_nx_c;
        u_nx_r  <= u_nx_c;
        fired_r <= fired_c;
      end
    end
  end

  // Registered outputs, aligned so strobes coincide with the WRITE state
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      spk_q     <= 1'b0;
      spk_tag_q <= '0;
      v_new_q   <= '0;
      u_new_q   <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == WRITE) && (state_d == IDLE);
      we_q   <= (state_d == WRITE);
      spk_q  <= (state_q == ACC) && fired_r;
      if (state_q == ACC) begin
        v_new_q <= v_nx_r;
        u_new_q <= u_nx_r;
        if (fired_r) begin
          spk_tag_q <= tag_q;
        end
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.tag         = tag_q;
  assign bus.write_en    = we_q;
  assign bus.spike_valid = spk_q;
  assign bus.spike_tag   = spk_tag_q;
  assign bus.v_new       = v_new_q;
  assign bus.u_new       = u_new_q;

endmodule

// File: doc/neuron_update_engine.md
NEURON_UPDATE_ENGINE -- requirements
Module: neuron_update_engine

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named clk and asyn_reset.
REQ-002 Parameters: NUMWIDTH, 16, MSB index of state words; values are signed Q8.8 held in NUMWIDTH+1 bits.
REQ-003 Parameters: NUMNEURONS, 2, neurons swept per step (power of two); TAGBITS, 1, log2(NUMNEURONS).
REQ-004 Parameters: A, 5 (0.0195); B, 51 (0.199); C, -16640 (-65.0); D, 2048 (8.0); VPEAK, 7680 (30.0); all Q8.8.
REQ-005 Ports: clk  in  1  clock; asyn_reset  in  1  async active-high reset.
REQ-006 Ports: start  in  1  begin one timestep sweep; busy  out  1  sweep in progress; done  out  1  one-cycle sweep-complete pulse.
REQ-007 Ports: tag  out  TAGBITS  neuron address to state register and input-current source.
REQ-008 Ports: v_in, u_in  in  NUMWIDTH+1  state read at tag; i_in  in  NUMWIDTH+1  input current for tag.
REQ-009 Ports: v_new, u_new  out  NUMWIDTH+1  write-back data; write_en  out  1  write strobe to state register.
REQ-010 Ports: spike_valid  out  1  spike pulse; spike_tag  out  TAGBITS  neuron that fired.

Function
REQ-011 FSM states SHALL be IDLE, READ, MUL, ACC, WRITE.
REQ-012 Transitions SHALL be IDLE->READ on start, READ->MUL->ACC->WRITE, then WRITE->READ with tag+1 or WRITE->IDLE after tag NUMNEURONS-1; exactly 4 cycles per neuron.
REQ-013 start SHALL be ignored while busy; busy SHALL be high in every state except IDLE.
REQ-014 tag SHALL be 0 at sweep start, SHALL hold constant from READ through WRITE, and SHALL NOT wrap mid-sweep.
REQ-015 READ SHALL register v_in, u_in, and i_in.
REQ-016 If registered v >= VPEAK (signed compare), the engine SHALL output v_new=C, u_new=sat(u+D), and spike_valid=1 with spike_tag=tag in the WRITE cycle.
REQ-017 Otherwise: v_new = sat(v + ((10*v*v)>>>16) + 5v + 35840 - u + i); u_new = sat(u + ((A*(((B*v)>>>8) - u))>>>8)).
REQ-018 Arithmetic SHALL use signed intermediates of at least 2*(NUMWIDTH+1)+4 bits, with arithmetic right shifts truncating toward negative infinity.
REQ-019 sat() SHALL clamp to [-65536, 65535].
REQ-020 write_en SHALL be high only in WRITE, for exactly one cycle per neuron.
REQ-021 spike_valid SHALL only be high in WRITE.
REQ-022 done SHALL pulse in the cycle after the final WRITE, coincident with the return to IDLE.
REQ-023 A start arriving in the same cycle as done SHALL be ignored; the next start is accepted from IDLE.

Reset
REQ-024 asyn_reset SHALL force state=IDLE, tag=0, busy=0, done=0, write_en=0, spike_valid=0, spike_tag=0, v_new=0, u_new=0, and all operand registers to 0, immediately.
REQ-025 Reset mid-sweep SHALL abort the sweep with no further write_en, and SHALL NOT generate done.
REQ-026 After reset deassertion the engine SHALL wait in IDLE for start.

Structure
REQ-027 A shared package SHALL hold the Q8.8 width constant, the A/B/C/D/VPEAK defaults, the FSM state encoding, and the saturate function.
REQ-028 The datapath arithmetic SHALL be one combinational sub-module, izh_datapath (v, u, i -> v_next, u_next, fired), instantiated once; the FSM stays in the top module.

Verification
REQ-029 The bench SHALL cover: v=0, u=0, i=0 -> write_en with v_new=35840, u_new=0, spike_valid=0.
REQ-030 The bench SHALL cover: v=7680, u=0 -> v_new=-16640, u_new=2048, spike_valid=1, spike_tag=tag.
REQ-031 The bench SHALL cover: v=-65280, u=0, i=0 -> v_new=65535 (saturated), no spike.
REQ-032 The bench SHALL cover: NUMNEURONS=2, start pulse -> write_en in cycles 4 and 8 with tags 0 then 1, done in cycle 9, busy low afterwards.
REQ-033 The bench SHALL cover: start reasserted while busy -> no restart; tag sequence unchanged.
REQ-034 The bench SHALL cover: asyn_reset asserted during MUL of tag 1 -> outputs zero immediately, no done, and a fresh start resumes from tag 0.
